// File: rtl/sar_search_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sar_search_ctrl
//  Purpose  : Successive-approximation search controller. Presents a trial
//             value to an external magnitude comparator (unknown on a, trial
//             on b), reads back g/l/e and resolves the unknown MSB-first,
//             one bit per clock, stopping early on equality.
//  Revision : 1.0  initial release
// ============================================================================
module sar_search_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           cmp_g,
    input  logic                           cmp_l,
    input  logic                           cmp_e,
    output logic [WIDTH-1:0]               trial,
    output logic                           busy,
    output logic                           done,
    output logic [WIDTH-1:0]               result,
    output logic                           exact,
    output logic [$clog2(WIDTH+1)-1:0]     cmp_count,
    output logic                           err
);

    // Bit-index width; a 1-bit operand still needs a 1-bit index register.
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = $clog2(WIDTH + 1);

    // First trial: only the MSB set.
    localparam logic [WIDTH-1:0] TRIAL_MSB = WIDTH'(1) << (WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SEARCH = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   trial_q, trial_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exact_q, exact_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic               code_legal;
    logic [WIDTH-1:0]   trial_upd;

    // Exactly one of g/l/e: odd population count, but not all three.
    assign code_legal = (cmp_g ^ cmp_l ^ cmp_e) & ~(cmp_g & cmp_l & cmp_e);

    // Next-state and datapath update for the two-state search sequencer.
    always_comb begin
        state_d   = state_q;
        trial_d   = trial_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        result_d  = result_q;
        exact_d   = exact_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        trial_upd = trial_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SEARCH;
                    trial_d = TRIAL_MSB;
                    idx_d   = IDX_TOP;
                    exact_d = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end

            ST_SEARCH: begin
                cnt_d = cnt_q + 1'b1;
                if (!code_legal) begin
                    // Comparator inconsistency aborts and reports the trial in flight.
                    err_d    = 1'b1;
                    done_d   = 1'b1;
                    result_d = trial_q;
                    exact_d  = 1'b0;
                    state_d  = ST_IDLE;
                end else if (cmp_e) begin
                    result_d = trial_q;
                    exact_d  = 1'b1;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    // a < trial: this bit overshoots, drop it; a > trial: keep it.
                    if (cmp_l) begin
                        trial_upd[idx_q] = 1'b0;
                    end
                    if (idx_q != '0) begin
                        trial_upd[idx_q - 1'b1] = 1'b1;
                        idx_d = idx_q - 1'b1;
                    end else begin
                        result_d = trial_upd;
                        exact_d  = 1'b0;
                        done_d   = 1'b1;
                        state_d  = ST_IDLE;
                    end
                    trial_d = trial_upd;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            trial_q  <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            exact_q  <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            result_q <= result_d;
            exact_q  <= exact_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign trial     = trial_q;
    assign busy      = (state_q == ST_SEARCH);
    assign done      = done_q;
    assign result    = result_q;
    assign exact     = exact_q;
    assign cmp_count = cnt_q;
    assign err       = err_q;

endmodule
`default_nettype wire
